// File: rtl/mux_canais_reg_if.sv
// Handshake and data bundle for mux_canais_reg: N flattened input channels,
// channel select and the registered result with its valid/ready pair.
interface mux_canais_reg_if #(
   parameter int LARGURA = 8,
   parameter int CANAIS  = 3,
   parameter int SEL_W   = 2
);
   logic [CANAIS*LARGURA-1:0] Entradas;
   logic [SEL_W-1:0]          Controle;
   logic                      entrada_valida;
   logic                      entrada_pronta;
   logic [LARGURA-1:0]        Resultado;
   logic                      saida_valida;
   logic                      saida_pronta;
   logic [SEL_W-1:0]          Canal_atual;
   logic                      erro_sel;

   modport master (
      output Entradas, Controle, entrada_valida, saida_pronta,
      input  entrada_pronta, Resultado, saida_valida, Canal_atual, erro_sel
   );

   modport slave (
      input  Entradas, Controle, entrada_valida, saida_pronta,
      output entrada_pronta, Resultado, saida_valida, Canal_atual, erro_sel
   );
endinterface

// File: rtl/mux_canais_reg.sv
// Registered N-channel multiplexer with a one-entry output buffer and valid/ready
// on both sides. Define MUX_CANAIS_VARREDURA_EN to add the round-robin scan input.
module mux_canais_reg #(
   parameter int LARGURA = 8,
   parameter int CANAIS  = 3,
   parameter int SEL_W   = 2
) (
   input  logic clock,
   input  logic reset,
`ifdef MUX_CANAIS_VARREDURA_EN
   input  logic varredura,
`endif
   mux_canais_reg_if.slave bus
);

   localparam logic [SEL_W-1:0] ULTIMO = SEL_W'(CANAIS - 1);

   generate
      if ((CANAIS < 2) || (CANAIS > 16) || ((1 << SEL_W) < CANAIS)) begin : g_param_chk
         $error("mux_canais_reg: CANAIS must be 2..16 and 2**SEL_W >= CANAIS");
      end
   endgenerate

   typedef enum logic {VAZIO = 1'b0, CHEIO = 1'b1} estado_t;

   estado_t            estado_q, estado_d;
   logic [LARGURA-1:0] resultado_q, resultado_d;
   logic [SEL_W-1:0]   canal_q, canal_d;
   logic               erro_q, erro_d;
   logic [SEL_W-1:0]   sel;
   logic               sel_ok;
   logic               aceita;

   function automatic logic [LARGURA-1:0] canal_de(
      input logic [CANAIS*LARGURA-1:0] v,
      input logic [SEL_W-1:0]          s
   );
      logic [LARGURA-1:0] r;
      r = '0;
      for (int k = 0; k < CANAIS; k++) begin
         if (s == SEL_W'(k)) r = v[k*LARGURA +: LARGURA];
      end
      return r;
   endfunction

   // Ready does not look at entrada_valida, so upstream may wait on it freely.
   assign bus.entrada_pronta = (estado_q == VAZIO) || bus.saida_pronta;
   assign aceita             = bus.entrada_valida && bus.entrada_pronta;

`ifdef MUX_CANAIS_VARREDURA_EN
   logic [SEL_W-1:0] varre_q, varre_d;

   always_comb begin
      sel_ok  = int'(bus.Controle) < CANAIS;
      sel     = sel_ok ? bus.Controle : ULTIMO;
      varre_d = varre_q;
      if (varredura) begin
         sel    = varre_q;
         sel_ok = 1'b1;
         if (aceita) varre_d = (varre_q == ULTIMO) ? '0 : varre_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) varre_q <= '0;
      else       varre_q <= varre_d;
   end
`else
   always_comb begin
      sel_ok = int'(bus.Controle) < CANAIS;
      sel    = sel_ok ? bus.Controle : ULTIMO;
   end
`endif

   always_comb begin
      estado_d    = estado_q;
      resultado_d = resultado_q;
      canal_d     = canal_q;
      erro_d      = erro_q;
      if (aceita) begin
         estado_d    = CHEIO;
         resultado_d = canal_de(bus.Entradas, sel);
         canal_d     = sel;
         if (!sel_ok) erro_d = 1'b1;
      end else if ((estado_q == CHEIO) && bus.saida_pronta) begin
         estado_d = VAZIO;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q    <= VAZIO;
         resultado_q <= '0;
         canal_q     <= '0;
         erro_q      <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         resultado_q <= resultado_d;
         canal_q     <= canal_d;
         erro_q      <= erro_d;
      end
   end

   assign bus.Resultado    = resultado_q;
   assign bus.Canal_atual  = canal_q;
   assign bus.erro_sel     = erro_q;
   assign bus.saida_valida = (estado_q == CHEIO);

endmodule
